// File: rtl/cc_serial_if.sv
// Serial front end for the combinational CC core: collects six 4-bit operand beats,
// drives a stable bundle to CC, waits CC_LAT cycles, captures cc_out_n and returns it.
module cc_serial_if #(
    parameter int unsigned CC_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [2:0] in_opt,
    input  logic       in_equ,
    output logic [3:0] cc_n0,
    output logic [3:0] cc_n1,
    output logic [3:0] cc_n2,
    output logic [3:0] cc_n3,
    output logic [3:0] cc_n4,
    output logic [3:0] cc_n5,
    output logic [2:0] cc_opt,
    output logic       cc_equ,
    input  logic [9:0] cc_out_n,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_data,
    output logic       err_ovr
);

    localparam int unsigned DW     = 4;
    localparam int unsigned OPTW   = 3;
    localparam int unsigned RW     = 10;
    localparam int unsigned NBEATS = 6;
    localparam int unsigned BCW    = 3;
    localparam int unsigned LCW    = 4;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;

    state_t          state, state_d;
    logic [BCW-1:0]  beat_cnt, beat_cnt_d;
    logic [LCW-1:0]  lat_cnt, lat_cnt_d;
    logic [DW-1:0]   n_q [NBEATS];
    logic [DW-1:0]   n_d [NBEATS];
    logic [OPTW-1:0] opt_d;
    logic            equ_d;
    logic            in_ready_d;
    logic            out_valid_d;
    logic [RW-1:0]   out_data_d;
    logic            err_d;
    logic            accept;
    logic            last_beat;
    logic            settled;

    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == BCW'(NBEATS - 1));
    assign settled   = (lat_cnt == LCW'(CC_LAT - 1));

    assign cc_n0 = n_q[0];
    assign cc_n1 = n_q[1];
    assign cc_n2 = n_q[2];
    assign cc_n3 = n_q[3];
    assign cc_n4 = n_q[4];
    assign cc_n5 = n_q[5];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = LOAD;
            LOAD: if (accept && last_beat) state_d = WAIT;
            WAIT: if (settled) state_d = OUT;
            OUT:  if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for counters, bundle and registered outputs
    always_comb begin
        beat_cnt_d  = beat_cnt;
        lat_cnt_d   = lat_cnt;
        for (int k = 0; k < NBEATS; k++) n_d[k] = n_q[k];
        opt_d       = cc_opt;
        equ_d       = cc_equ;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
        err_d       = in_valid && !in_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    n_d[0]     = in_data;
                    opt_d      = in_opt;
                    equ_d      = in_equ;
                    beat_cnt_d = BCW'(1);
                end
            end
            LOAD: begin
                if (accept) begin
                    for (int k = 1; k < NBEATS; k++) begin
                        if (beat_cnt == BCW'(k)) n_d[k] = in_data;
                    end
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        lat_cnt_d  = '0;
                    end else begin
                        beat_cnt_d = beat_cnt + BCW'(1);
                    end
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt + LCW'(1);
                if (settled) begin
                    out_data_d  = cc_out_n;
                    out_valid_d = 1'b1;
                    lat_cnt_d   = '0;
                end
            end
            OUT: begin
                if (out_valid && out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            lat_cnt   <= '0;
            for (int k = 0; k < NBEATS; k++) n_q[k] <= '0;
            cc_opt    <= '0;
            cc_equ    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            err_ovr   <= 1'b0;
        end else begin
            beat_cnt  <= beat_cnt_d;
            lat_cnt   <= lat_cnt_d;
            for (int k = 0; k < NBEATS; k++) n_q[k] <= n_d[k];
            cc_opt    <= opt_d;
            cc_equ    <= equ_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            in_ready  <= in_ready_d;
            err_ovr   <= err_d;
        end
    end

endmodule

// File: tb/tb_cc_serial_if.sv
// Bench for cc_serial_if: a stand-in CC function closes the loop; each frame's
// expected result, latency and bundle come from the operands the bench itself sent.
module tb_cc_serial_if;

    localparam int unsigned CC_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [2:0] in_opt;
    logic       in_equ;
    logic [3:0] cc_n0, cc_n1, cc_n2, cc_n3, cc_n4, cc_n5;
    logic [2:0] cc_opt;
    logic       cc_equ;
    logic [9:0] cc_out_n;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;
    logic       err_ovr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    cc_serial_if #(.CC_LAT(CC_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_opt(in_opt), .in_equ(in_equ),
        .cc_n0(cc_n0), .cc_n1(cc_n1), .cc_n2(cc_n2),
        .cc_n3(cc_n3), .cc_n4(cc_n4), .cc_n5(cc_n5),
        .cc_opt(cc_opt), .cc_equ(cc_equ), .cc_out_n(cc_out_n),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_ovr(err_ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in CC: position-weighted sum so every operand slot and opt/equ matter
    function automatic logic [9:0] cc_core(input logic [23:0] n, input logic [2:0] o, input logic e);
        int acc = 0;
        for (int k = 0; k < 6; k++) acc += (3 + 7 * k) * int'(n[4*k +: 4]);
        acc = acc ^ (int'({o, e}) << 6) ^ int'(o);
        return 10'(acc);
    endfunction

    assign cc_out_n = cc_core({cc_n5, cc_n4, cc_n3, cc_n2, cc_n1, cc_n0}, cc_opt, cc_equ);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one beat and hold it until an edge where in_ready was high
    task automatic send_beat(input logic [3:0] d, input logic [2:0] o, input logic e);
        bit rdy = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_opt   = o;
        in_equ   = e;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
        end
        if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gap<0: random 0..2 idle cycles between beats; stall==0: out_ready high all frame
    task automatic run_frame(input logic [23:0] ops, input logic [2:0] opt, input logic equ,
                             input int gap, input int stall, input bit flood);
        logic [9:0] exp;
        int t5;
        bit seen;
        exp = cc_core(ops, opt, equ);
        out_ready = (stall == 0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) idle_cycles((gap < 0) ? int'($urandom_range(0, 2)) : gap);
            if (k == 0) send_beat(ops[4*k +: 4], opt, equ);
            else        send_beat(ops[4*k +: 4], 3'($urandom), 1'($urandom));
        end
        t5 = cyc;
        in_valid = flood;
        in_data  = 4'hA;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                chk("bundle_wait", 32'({cc_n5, cc_n4, cc_n3, cc_n2, cc_n1, cc_n0}), 32'(ops));
                chk("rdy_wait", 32'(in_ready), 32'd0);
            end
            if (flood && i > 0) chk("err_flood", 32'(err_ovr), 32'd1);
        end
        chk("valid_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc - t5), 32'(CC_LAT));
        chk("out_data", 32'(out_data), 32'(exp));
        chk("cc_opt", 32'(cc_opt), 32'(opt));
        chk("cc_equ", 32'(cc_equ), 32'(equ));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(exp));
            chk("hold_rdy", 32'(in_ready), 32'd0);
            if (flood) chk("err_stall", 32'(err_ovr), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_valid", 32'(out_valid), 32'd0);
        chk("hs_rdy", 32'(in_ready), 32'd1);
        chk("hs_data", 32'(out_data), 32'(exp));
        chk("hs_err", 32'(err_ovr), 32'd0);
        chk("bundle_hold", 32'({cc_n5, cc_n4, cc_n3, cc_n2, cc_n1, cc_n0}), 32'(ops));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_err"}, 32'(err_ovr), 32'd0);
        chk({tag, "_bundle"}, 32'({cc_n5, cc_n4, cc_n3, cc_n2, cc_n1, cc_n0, cc_opt, cc_equ}), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_opt    = '0;
        in_equ    = 1'b0;
        out_ready = 1'b0;
        #12;
        chk_reset_state("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);

        run_frame(24'h654321, 3'b000, 1'b0, 0, 0, 1'b0);
        run_frame(24'h654321, 3'b000, 1'b1, 0, 3, 1'b0);
        run_frame(24'h2F3087, 3'b001, 1'b1, 0, 2, 1'b0);
        run_frame(24'h1A9C4E, 3'b010, 1'b0, 2, 10, 1'b0);
        run_frame(24'h5B0D31, 3'b110, 1'b0, 0, 4, 1'b1);
        run_frame(24'hE7F820, 3'b101, 1'b1, 0, 1, 1'b0);

        // Abort a frame after three beats with an asynchronous reset
        send_beat(4'h9, 3'b111, 1'b1);
        send_beat(4'hC, 3'b000, 1'b0);
        send_beat(4'h3, 3'b000, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
        run_frame(24'h0F1E2D, 3'b011, 1'b1, 0, 2, 1'b0);

        for (int f = 0; f < 40; f++) begin
            run_frame(24'($urandom), 3'($urandom), 1'($urandom), -1,
                      int'($urandom_range(0, 5)), 1'($urandom));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
